periph_req_buffer: RTL and testbench
====================================

Name: periph_req_buffer

Overview:
- Timing-cut and outstanding-transaction limiter on a core's peripheral data path.
- Sits between the core data demux peripheral port (slave side) and the cluster peripheral interconnect (master side).
- Registers requests in a 2-entry buffer and passes responses straight through.
- Caps in-flight peripheral transactions per core and exports a stall perf event.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, write/read data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
ID_WIDTH, 5, transaction id width, carried unchanged
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests; legal range >= 1

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_req_i  in  1  upstream request
s_add_i  in  ADDR_WIDTH  address
s_wen_i  in  1  1=read, 0=write
s_wdata_i  in  DATA_WIDTH  write data
s_be_i  in  BE_WIDTH  byte enables
s_id_i  in  ID_WIDTH  transaction id
s_gnt_o  out  1  request accepted
s_r_valid_o  out  1  response valid
s_r_rdata_o  out  DATA_WIDTH  response data
s_r_opc_o  out  1  response error flag
s_r_id_o  out  ID_WIDTH  response id
m_req_o  out  1  downstream request
m_add_o  out  ADDR_WIDTH  address
m_wen_o  out  1  read/write
m_wdata_o  out  DATA_WIDTH  write data
m_be_o  out  BE_WIDTH  byte enables
m_id_o  out  ID_WIDTH  id
m_gnt_i  in  1  downstream grant
m_r_valid_i  in  1  downstream response valid
m_r_rdata_i  in  DATA_WIDTH  response data
m_r_opc_i  in  1  response error flag
m_r_id_i  in  ID_WIDTH  response id
perf_stall_o  out  1  cycle event: s_req_i high and s_gnt_o low
err_o  out  1  one-cycle pulse: response received with zero outstanding

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - Buffer empty, outstanding count 0, err_o 0.
  - Hence m_req_o=0 and s_gnt_o=1.
  - m_* payload outputs are 0.
- Grant:
  - s_gnt_o = (buf_cnt < 2) && (outst < MAX_OUTSTANDING).
  - s_gnt_o depends on registered state only; no combinational path from s_req_i or m_gnt_i.
- Accept: s_req_i && s_gnt_o pushes {add, wen, wdata, be, id} into the buffer tail.
- Request latency:
  - Pushed entry appears on m_* no earlier than the next cycle.
  - With an empty buffer it appears exactly the next cycle.
- Master side:
  - m_req_o = buffer non-empty; m_* always shows the head entry.
  - Pop on m_req_o && m_gnt_i.
  - Head payload stays stable while m_req_o is high and m_gnt_i is low.
- Throughput: one request per cycle sustained when m_gnt_i is held high. Push and pop in the same cycle are both legal, including when buf_cnt=2; the grant rule still blocks push at buf_cnt=2 that cycle.
- Outstanding counter (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on accept, -1 on m_r_valid_i.
  - Simultaneous accept and response: net unchanged.
  - Counter includes buffered, not-yet-granted entries.
- Response path: combinational pass-through, zero latency. s_r_valid_o=m_r_valid_i; rdata, opc and id copied unchanged.
- Protocol error: m_r_valid_i with outst==0 and no same-cycle accept.
  - Counter stays 0 (no underflow).
  - err_o pulses high the next cycle.
  - The response is still forwarded.
- Saturation: at outst==MAX_OUTSTANDING, s_gnt_o=0 until a response arrives. The cycle after that response, s_gnt_o returns to 1 if buf_cnt<2.
- Reset mid-operation: buffered requests are discarded and the counter clears; responses arriving after reset may raise err_o.
- perf_stall_o: combinational, s_req_i && !s_gnt_o.

Decomposition:
- Package periph_buf_pkg:
  - Typedef periph_req_t struct {add, wen, wdata, be, id}, parameterised by localparam widths matching the defaults.
  - Localparam BUF_DEPTH=2.
- One sub-module, periph_req_fifo2: 2-entry FIFO of periph_req_t.
  - Ports: push, pop, full, empty, count, head.
  - Handles simultaneous push/pop.
- Top level holds the outstanding counter, grant logic, error and perf logic.

Test Plan:
- Single read: reset, then s_req_i=1, add=0x1020_0004, wen=1, id=3 for one cycle.
  - Required: s_gnt_o=1; next cycle m_req_o=1, m_add_o=0x1020_0004, m_id_o=3.
  - Drive m_gnt_i=1, then m_r_valid_i with rdata 0xCAFE_F00D, id 3. Required: same cycle s_r_valid_o=1, s_r_rdata_o=0xCAFE_F00D, s_r_id_o=3; outst returns to 0.
- Back-pressure: m_gnt_i=0, 3 consecutive writes offered.
  - Required: first two granted, third sees s_gnt_o=0 and perf_stall_o=1.
  - Head payload stable. Raise m_gnt_i: entries emerge in order.
- Outstanding cap, MAX_OUTSTANDING=4: m_gnt_i=1, no responses, 6 requests offered.
  - Required: exactly 4 granted, then s_gnt_o=0.
  - One response: grant resumes the next cycle; fifth request accepted.
- Streaming: m_gnt_i=1, responses 2 cycles after each grant, 20 back-to-back requests.
  - Required: 20 accepts in 20 cycles after the first; ordering preserved.
  - Simultaneous accept and response leaves outst constant.
- Spurious response: m_r_valid_i=1 with outst=0.
  - Required: err_o=1 for exactly one cycle next; counter stays 0; response forwarded.
- Async reset: assert rst_ni low mid-stream with 2 entries buffered and outst=3.
  - Required: immediately m_req_o=0 and s_gnt_o=1.
  - After release, a new request flows normally.

Source files
------------

// File: rtl/periph_buf_pkg.sv
// Shared types for the peripheral request buffer: request payload struct
// and buffer geometry.
package periph_buf_pkg;

   localparam int unsigned PB_ADDR_W = 32;
   localparam int unsigned PB_DATA_W = 32;
   localparam int unsigned PB_BE_W   = PB_DATA_W / 8;
   localparam int unsigned PB_ID_W   = 5;
   localparam int unsigned BUF_DEPTH = 2;

   // One buffered peripheral request as seen on the master side.
   typedef struct packed {
      logic [PB_ADDR_W-1:0] add;
      logic                 wen;
      logic [PB_DATA_W-1:0] wdata;
      logic [PB_BE_W-1:0]   be;
      logic [PB_ID_W-1:0]   id;
   } periph_req_t;

endpackage

// File: rtl/periph_req_fifo2.sv
// Two-entry request FIFO. The head entry is always visible on head_o and is
// register-backed, so the master-side payload has no combinational input path.
// Push is ignored when full; push and pop may occur in the same cycle.
module periph_req_fifo2
   import periph_buf_pkg::*;
#(
   parameter type req_t = periph_req_t
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  req_t       data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output logic [1:0] count_o,
   output req_t       head_o
);

   req_t       mem_q [BUF_DEPTH];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic       do_push;
   logic       do_pop;

   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Occupancy update: simultaneous push and pop leave the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage and pointers; entries clear on reset so m_* payload reads zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/periph_req_buffer.sv
// Timing cut and outstanding-transaction limiter between a core's data demux
// peripheral port and the cluster peripheral interconnect. Requests are
// registered in a 2-entry FIFO; responses pass straight through.
module periph_req_buffer
   import periph_buf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH        = 5,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  s_req_i,
   input  logic [ADDR_WIDTH-1:0] s_add_i,
   input  logic                  s_wen_i,
   input  logic [DATA_WIDTH-1:0] s_wdata_i,
   input  logic [BE_WIDTH-1:0]   s_be_i,
   input  logic [ID_WIDTH-1:0]   s_id_i,
   output logic                  s_gnt_o,
   output logic                  s_r_valid_o,
   output logic [DATA_WIDTH-1:0] s_r_rdata_o,
   output logic                  s_r_opc_o,
   output logic [ID_WIDTH-1:0]   s_r_id_o,
   output logic                  m_req_o,
   output logic [ADDR_WIDTH-1:0] m_add_o,
   output logic                  m_wen_o,
   output logic [DATA_WIDTH-1:0] m_wdata_o,
   output logic [BE_WIDTH-1:0]   m_be_o,
   output logic [ID_WIDTH-1:0]   m_id_o,
   input  logic                  m_gnt_i,
   input  logic                  m_r_valid_i,
   input  logic [DATA_WIDTH-1:0] m_r_rdata_i,
   input  logic                  m_r_opc_i,
   input  logic [ID_WIDTH-1:0]   m_r_id_i,
   output logic                  perf_stall_o,
   output logic                  err_o
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   // Local payload type so non-default widths are carried correctly.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] add;
      logic                  wen;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
      logic [ID_WIDTH-1:0]   id;
   } req_t;

   req_t          push_data;
   req_t          head;
   logic          accept;
   logic          pop;
   logic          buf_full;
   logic          buf_empty;
   logic [1:0]    buf_cnt_unused;
   logic          outst_ok;
   logic [OW-1:0] outst_q;
   logic [OW-1:0] outst_d;
   logic          err_q;
   logic          err_d;

   assign push_data = '{add: s_add_i, wen: s_wen_i, wdata: s_wdata_i,
                        be: s_be_i, id: s_id_i};

   // Grant is a function of registered state only: FIFO occupancy and the
   // outstanding count, which already includes buffered entries.
   assign outst_ok = (outst_q < OW'(MAX_OUTSTANDING));
   assign s_gnt_o  = !buf_full && outst_ok;
   assign accept   = s_req_i && s_gnt_o;
   assign pop      = m_req_o && m_gnt_i;

   periph_req_fifo2 #(
      .req_t (req_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (push_data),
      .pop_i   (pop),
      .full_o  (buf_full),
      .empty_o (buf_empty),
      .count_o (buf_cnt_unused),
      .head_o  (head)
   );

   assign m_req_o   = !buf_empty;
   assign m_add_o   = head.add;
   assign m_wen_o   = head.wen;
   assign m_wdata_o = head.wdata;
   assign m_be_o    = head.be;
   assign m_id_o    = head.id;

   // Responses are forwarded with zero latency, including spurious ones.
   assign s_r_valid_o = m_r_valid_i;
   assign s_r_rdata_o = m_r_rdata_i;
   assign s_r_opc_o   = m_r_opc_i;
   assign s_r_id_o    = m_r_id_i;

   assign perf_stall_o = s_req_i && !s_gnt_o;
   assign err_o        = err_q;

   // Outstanding count: +1 on accept, -1 on response; a response with nothing
   // outstanding (and no same-cycle accept) holds at zero and flags an error.
   always_comb begin
      outst_d = outst_q;
      err_d   = 1'b0;
      case ({accept, m_r_valid_i})
         2'b10: outst_d = outst_q + OW'(1);
         2'b01: begin
            if (outst_q == OW'(0)) begin
               err_d = 1'b1;
            end else begin
               outst_d = outst_q - OW'(1);
            end
         end
         default: outst_d = outst_q;
      endcase
   end

   // Counter and one-cycle error pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_periph_req_buffer.sv
// Self-checking bench for periph_req_buffer: a negedge monitor keeps a
// request scoreboard and an outstanding-count model; directed sequences
// cover single read, back-pressure, the outstanding cap, streaming,
// spurious responses and mid-stream asynchronous reset.
module tb_periph_req_buffer;

   localparam int MAX_OUT = 4;

   typedef struct {
      logic [31:0] add;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [4:0]  id;
   } req_s;

   typedef struct {
      int         due;
      logic [4:0] id;
   } pend_s;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        s_req_i;
   logic [31:0] s_add_i;
   logic        s_wen_i;
   logic [31:0] s_wdata_i;
   logic [3:0]  s_be_i;
   logic [4:0]  s_id_i;
   logic        s_gnt_o;
   logic        s_r_valid_o;
   logic [31:0] s_r_rdata_o;
   logic        s_r_opc_o;
   logic [4:0]  s_r_id_o;
   logic        m_req_o;
   logic [31:0] m_add_o;
   logic        m_wen_o;
   logic [31:0] m_wdata_o;
   logic [3:0]  m_be_o;
   logic [4:0]  m_id_o;
   logic        m_gnt_i;
   logic        m_r_valid_i;
   logic [31:0] m_r_rdata_i;
   logic        m_r_opc_i;
   logic [4:0]  m_r_id_i;
   logic        perf_stall_o;
   logic        err_o;

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   int cyc   = 0;
   int m_outst = 0;
   bit m_err = 1'b0;
   bit auto_rsp = 1'b0;
   req_s  exp_q[$];
   pend_s pend_q[$];

   periph_req_buffer #(
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .s_req_i      (s_req_i),
      .s_add_i      (s_add_i),
      .s_wen_i      (s_wen_i),
      .s_wdata_i    (s_wdata_i),
      .s_be_i       (s_be_i),
      .s_id_i       (s_id_i),
      .s_gnt_o      (s_gnt_o),
      .s_r_valid_o  (s_r_valid_o),
      .s_r_rdata_o  (s_r_rdata_o),
      .s_r_opc_o    (s_r_opc_o),
      .s_r_id_o     (s_r_id_o),
      .m_req_o      (m_req_o),
      .m_add_o      (m_add_o),
      .m_wen_o      (m_wen_o),
      .m_wdata_o    (m_wdata_o),
      .m_be_o       (m_be_o),
      .m_id_o       (m_id_o),
      .m_gnt_i      (m_gnt_i),
      .m_r_valid_i  (m_r_valid_i),
      .m_r_rdata_i  (m_r_rdata_i),
      .m_r_opc_i    (m_r_opc_i),
      .m_r_id_i     (m_r_id_i),
      .perf_stall_o (perf_stall_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            m_r_valid_i = 1'b1;
            m_r_id_i    = pend_q[0].id;
            m_r_rdata_i = 32'hD000_0000 | {27'd0, pend_q[0].id};
            m_r_opc_i   = pend_q[0].id[0];
            void'(pend_q.pop_front());
         end else begin
            m_r_valid_i = 1'b0;
         end
      end
   endtask

   task automatic set_req(input logic req, input logic [31:0] add, input logic wen,
                          input logic [31:0] wd, input logic [3:0] be, input logic [4:0] id);
      s_req_i   = req;
      s_add_i   = add;
      s_wen_i   = wen;
      s_wdata_i = wd;
      s_be_i    = be;
      s_id_i    = id;
   endtask

   task automatic set_rsp(input logic v, input logic [4:0] id, input logic [31:0] d, input logic opc);
      m_r_valid_i = v;
      m_r_id_i    = id;
      m_r_rdata_i = d;
      m_r_opc_i   = opc;
   endtask

   // Cycle counter used to schedule automatic responses.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Negedge monitor: scoreboard for master-side requests plus a reference
   // model of the outstanding count, grant, stall and error pulse.
   initial begin
      req_s  r;
      pend_s p;
      bit    exp_gnt;
      bit    acc;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            exp_q.delete();
            pend_q.delete();
            m_outst = 0;
            m_err   = 1'b0;
         end else begin
            exp_gnt = (exp_q.size() < 2) && (m_outst < MAX_OUT);
            chk("gnt", 64'(s_gnt_o), 64'(exp_gnt));
            chk("stall", 64'(perf_stall_o), 64'(s_req_i && !exp_gnt));
            chk("m_req", 64'(m_req_o), 64'(exp_q.size() != 0));
            chk("err", 64'(err_o), 64'(m_err));
            chk("outst", 64'(dut.outst_q), 64'(m_outst));
            chk("r_valid", 64'(s_r_valid_o), 64'(m_r_valid_i));
            if (m_r_valid_i) begin
               chk("r_rdata", 64'(s_r_rdata_o), 64'(m_r_rdata_i));
               chk("r_id", 64'(s_r_id_o), 64'(m_r_id_i));
               chk("r_opc", 64'(s_r_opc_o), 64'(m_r_opc_i));
            end
            acc = s_req_i && exp_gnt;
            if (exp_q.size() != 0) begin
               r = exp_q[0];
               chk("m_add", 64'(m_add_o), 64'(r.add));
               chk("m_wen", 64'(m_wen_o), 64'(r.wen));
               chk("m_wdata", 64'(m_wdata_o), 64'(r.wdata));
               chk("m_be", 64'(m_be_o), 64'(r.be));
               chk("m_id", 64'(m_id_o), 64'(r.id));
               if (m_gnt_i) begin
                  void'(exp_q.pop_front());
                  p.due = cyc + 2;
                  p.id  = r.id;
                  pend_q.push_back(p);
               end
            end
            if (acc) begin
               r.add = s_add_i; r.wen = s_wen_i; r.wdata = s_wdata_i;
               r.be = s_be_i; r.id = s_id_i;
               exp_q.push_back(r);
               n_acc++;
            end
            m_err = m_r_valid_i && (m_outst == 0) && !acc;
            if (acc && !m_r_valid_i) begin
               m_outst++;
            end else if (!acc && m_r_valid_i && m_outst > 0) begin
               m_outst--;
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // Directed stimulus.
   initial begin
      int n0;
      rst_ni  = 1'b0;
      m_gnt_i = 1'b0;
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      #2;
      chk("rst_m_req", 64'(m_req_o), 64'd0);
      chk("rst_gnt", 64'(s_gnt_o), 64'd1);
      chk("rst_m_add", 64'(m_add_o), 64'd0);
      chk("rst_m_wdata", 64'(m_wdata_o), 64'd0);
      chk("rst_m_id", 64'(m_id_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // Single read
      set_req(1'b1, 32'h1020_0004, 1'b1, 32'd0, 4'hF, 5'd3);
      #1 chk("rd_gnt", 64'(s_gnt_o), 64'd1);
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      #1;
      chk("rd_m_req", 64'(m_req_o), 64'd1);
      chk("rd_m_add", 64'(m_add_o), 64'h1020_0004);
      chk("rd_m_id", 64'(m_id_o), 64'd3);
      m_gnt_i = 1'b1;
      tick();
      m_gnt_i = 1'b0;
      set_rsp(1'b1, 5'd3, 32'hCAFE_F00D, 1'b0);
      #1;
      chk("rd_r_valid", 64'(s_r_valid_o), 64'd1);
      chk("rd_r_rdata", 64'(s_r_rdata_o), 64'hCAFE_F00D);
      chk("rd_r_id", 64'(s_r_id_o), 64'd3);
      tick();
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      #1 chk("rd_outst0", 64'(dut.outst_q), 64'd0);

      // Spurious response with nothing outstanding
      tick();
      set_rsp(1'b1, 5'd9, 32'h1234_5678, 1'b1);
      #1;
      chk("sp_fwd_valid", 64'(s_r_valid_o), 64'd1);
      chk("sp_fwd_data", 64'(s_r_rdata_o), 64'h1234_5678);
      tick();
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("sp_err_hi", 64'(err_o), 64'd1);
      chk("sp_outst0", 64'(dut.outst_q), 64'd0);
      tick();
      #1 chk("sp_err_lo", 64'(err_o), 64'd0);

      // Back-pressure: three writes with the interconnect stalled
      n0 = n_acc;
      m_gnt_i = 1'b0;
      set_req(1'b1, 32'hA000_0000, 1'b0, 32'h1111_1111, 4'h1, 5'd1);
      tick();
      set_req(1'b1, 32'hA000_0004, 1'b0, 32'h2222_2222, 4'h3, 5'd2);
      tick();
      set_req(1'b1, 32'hA000_0008, 1'b0, 32'h3333_3333, 4'h7, 5'd4);
      #1;
      chk("bp_gnt0", 64'(s_gnt_o), 64'd0);
      chk("bp_stall", 64'(perf_stall_o), 64'd1);
      chk("bp_head", 64'(m_add_o), 64'hA000_0000);
      tick();
      tick();
      #1 chk("bp_head_stable", 64'(m_wdata_o), 64'h1111_1111);
      m_gnt_i = 1'b1;
      tick();
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      tick();
      tick();
      m_gnt_i = 1'b0;
      #1 chk("bp_acc3", 64'(n_acc - n0), 64'd3);
      for (int i = 0; i < 3; i++) begin
         set_rsp(1'b1, 5'd1, 32'd0, 1'b0);
         tick();
      end
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      tick();

      // Outstanding cap
      n0 = n_acc;
      m_gnt_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_req(1'b1, 32'hB000_0000 + 32'(i * 4), 1'b1, 32'd0, 4'hF, 5'(i + 8));
         tick();
      end
      #1;
      chk("cap_acc4", 64'(n_acc - n0), 64'd4);
      chk("cap_gnt0", 64'(s_gnt_o), 64'd0);
      set_rsp(1'b1, 5'd8, 32'hB0B0_0008, 1'b0);
      tick();
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      #1 chk("cap_resume", 64'(s_gnt_o), 64'd1);
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      #1 chk("cap_acc5", 64'(n_acc - n0), 64'd5);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_rsp(1'b1, 5'(i + 9), 32'd0, 1'b0);
         tick();
      end
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      m_gnt_i = 1'b0;
      tick();

      // Streaming with automatic responses two cycles after each grant
      pend_q.delete();
      auto_rsp = 1'b1;
      m_gnt_i  = 1'b1;
      n0 = n_acc;
      for (int i = 0; i < 20; i++) begin
         set_req(1'b1, 32'h2000_0000 + 32'(i * 4), 1'(i), 32'h5A00_0000 + 32'(i),
                 4'(i), 5'(i));
         tick();
      end
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      repeat (8) tick();
      auto_rsp = 1'b0;
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("st_acc20", 64'(n_acc - n0), 64'd20);
      chk("st_outst0", 64'(dut.outst_q), 64'd0);
      tick();

      // Async reset with two entries buffered and three outstanding
      m_gnt_i = 1'b1;
      set_req(1'b1, 32'hC000_0000, 1'b1, 32'd0, 4'hF, 5'd20);
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      tick();
      m_gnt_i = 1'b0;
      set_req(1'b1, 32'hC000_0004, 1'b1, 32'd0, 4'hF, 5'd21);
      tick();
      set_req(1'b1, 32'hC000_0008, 1'b1, 32'd0, 4'hF, 5'd22);
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      #1 chk("ar_pre_outst3", 64'(dut.outst_q), 64'd3);
      #1 rst_ni = 1'b0;
      #1;
      chk("ar_m_req0", 64'(m_req_o), 64'd0);
      chk("ar_gnt1", 64'(s_gnt_o), 64'd1);
      chk("ar_outst0", 64'(dut.outst_q), 64'd0);
      tick();
      #1 rst_ni = 1'b1;
      tick();
      set_req(1'b1, 32'hD000_0040, 1'b0, 32'hFEED_BEEF, 4'hC, 5'd30);
      tick();
      set_req(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 5'd0);
      #1;
      chk("ar_new_req", 64'(m_req_o), 64'd1);
      chk("ar_new_add", 64'(m_add_o), 64'hD000_0040);
      m_gnt_i = 1'b1;
      tick();
      m_gnt_i = 1'b0;
      set_rsp(1'b1, 5'd30, 32'd0, 1'b0);
      tick();
      set_rsp(1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      #1;
      chk("end_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("end_outst0", 64'(dut.outst_q), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
